// File: rtl/alu_seq_exec.sv
// alu_seq_exec: multicycle ALU executing a 4-bit ALUControl code over a
// start/busy/done handshake. Logic/arithmetic ops finish in one cycle.
// Shifts use a serial 1-bit-per-cycle shifter by default.
//
// Optional build macro ALU_SEQ_BARREL_SHIFT_EN: shifts use a combinational
// barrel shifter, there is no SHIFT state and no counter, and every code
// completes with latency 1.
//
// Ports:
//   clk        clock, rising edge
//   reset      synchronous active-high reset
//   start      request, sampled only in IDLE
//   ALUControl operation code, captured with start
//   SrcA/SrcB  operands, captured with start; SrcB[SHAMT_W-1:0] = shift amount
//   busy       high while a serial shift is in flight
//   done       one-cycle completion pulse
//   ALUResult  registered result, held until the next completion
//   Zero       registered, ALUResult == 0
//   IllegalOp  registered, completed code was undefined
module alu_seq_exec #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned SHAMT_W = 5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [3:0]         ALUControl,
    input  logic [WIDTH-1:0]   SrcA,
    input  logic [WIDTH-1:0]   SrcB,
    output logic               busy,
    output logic               done,
    output logic [WIDTH-1:0]   ALUResult,
    output logic               Zero,
    output logic               IllegalOp
);

    localparam logic [3:0] OP_ADD   = 4'h0;
    localparam logic [3:0] OP_SUB   = 4'h1;
    localparam logic [3:0] OP_AND   = 4'h2;
    localparam logic [3:0] OP_OR    = 4'h3;
    localparam logic [3:0] OP_XOR   = 4'h4;
    localparam logic [3:0] OP_SLT   = 4'h5;
    localparam logic [3:0] OP_SLTU  = 4'h6;
    localparam logic [3:0] OP_SLL   = 4'h7;
    localparam logic [3:0] OP_SRL   = 4'h8;
    localparam logic [3:0] OP_SRA   = 4'h9;
    localparam logic [3:0] OP_LUI   = 4'hA;
    localparam logic [3:0] OP_AUIPC = 4'hB;

`ifdef ALU_SEQ_BARREL_SHIFT_EN
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DONE = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;
`endif

    state_t             state_q, state_d;
    logic               busy_d, done_d, zero_d, ill_d;
    logic [WIDTH-1:0]   res_d;
    logic [SHAMT_W-1:0] shamt_c;

    assign shamt_c = SrcB[SHAMT_W-1:0];

    // Single-cycle result. Shift codes return SrcA in the serial build; that
    // path is only taken there when the shift amount is zero.
    function automatic logic [WIDTH-1:0] alu_comb(
        input logic [3:0]       op,
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b
    );
        logic [WIDTH-1:0] r;
        r = '0;
        case (op)
            OP_ADD, OP_AUIPC: r = a + b;
            OP_SUB:           r = a - b;
            OP_AND:           r = a & b;
            OP_OR:            r = a | b;
            OP_XOR:           r = a ^ b;
            OP_SLT:           r = ($signed(a) < $signed(b)) ? WIDTH'(1) : '0;
            OP_SLTU:          r = (a < b) ? WIDTH'(1) : '0;
`ifdef ALU_SEQ_BARREL_SHIFT_EN
            OP_SLL:           r = a << b[SHAMT_W-1:0];
            OP_SRL:           r = a >> b[SHAMT_W-1:0];
            OP_SRA:           r = $unsigned($signed(a) >>> b[SHAMT_W-1:0]);
`else
            OP_SLL, OP_SRL, OP_SRA: r = a;
`endif
            OP_LUI:           r = b;
            default:          r = '0;
        endcase
        return r;
    endfunction

    function automatic logic is_illegal(input logic [3:0] op);
        return op[3:2] == 2'b11;
    endfunction

`ifndef ALU_SEQ_BARREL_SHIFT_EN
    logic [3:0]         op_q, op_d;
    logic [WIDTH-1:0]   work_q, work_d, step_c;
    logic [SHAMT_W-1:0] cnt_q, cnt_d;

    function automatic logic is_shift(input logic [3:0] op);
        return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
    endfunction

    // One-bit step of the serial shifter for the latched op
    always_comb begin
        step_c = work_q;
        case (op_q)
            OP_SLL:  step_c = {work_q[WIDTH-2:0], 1'b0};
            OP_SRL:  step_c = {1'b0, work_q[WIDTH-1:1]};
            OP_SRA:  step_c = {work_q[WIDTH-1], work_q[WIDTH-1:1]};
            default: step_c = work_q;
        endcase
    end
`endif

    // Next-state and next-output logic
    always_comb begin
        state_d = state_q;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        res_d   = ALUResult;
        zero_d  = Zero;
        ill_d   = IllegalOp;
`ifndef ALU_SEQ_BARREL_SHIFT_EN
        op_d    = op_q;
        work_d  = work_q;
        cnt_d   = cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
`ifndef ALU_SEQ_BARREL_SHIFT_EN
                    if (is_shift(ALUControl) && (shamt_c != '0)) begin
                        op_d    = ALUControl;
                        work_d  = SrcA;
                        cnt_d   = shamt_c;
                        busy_d  = 1'b1;
                        state_d = SHIFT;
                    end else
`endif
                    begin
                        res_d   = alu_comb(ALUControl, SrcA, SrcB);
                        zero_d  = (res_d == '0);
                        ill_d   = is_illegal(ALUControl);
                        done_d  = 1'b1;
                        state_d = DONE;
                    end
                end
            end
`ifndef ALU_SEQ_BARREL_SHIFT_EN
            SHIFT: begin
                work_d = step_c;
                cnt_d  = cnt_q - SHAMT_W'(1);
                // Counter at 1 means this step is the last one
                if (cnt_q == SHAMT_W'(1)) begin
                    res_d   = step_c;
                    zero_d  = (step_c == '0);
                    ill_d   = 1'b0;
                    done_d  = 1'b1;
                    state_d = DONE;
                end else begin
                    busy_d  = 1'b1;
                end
            end
`endif
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            ALUResult <= '0;
            Zero      <= 1'b1;
            IllegalOp <= 1'b0;
`ifndef ALU_SEQ_BARREL_SHIFT_EN
            op_q      <= 4'h0;
            work_q    <= '0;
            cnt_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            busy      <= busy_d;
            done      <= done_d;
            ALUResult <= res_d;
            Zero      <= zero_d;
            IllegalOp <= ill_d;
`ifndef ALU_SEQ_BARREL_SHIFT_EN
            op_q      <= op_d;
            work_q    <= work_d;
            cnt_q     <= cnt_d;
`endif
        end
    end

endmodule

// File: tb/tb_alu_seq_exec.sv
// Self-checking bench for alu_seq_exec: table-driven ops with a result
// scoreboard, plus hand sequences for start-while-busy and reset mid-shift.
module tb_alu_seq_exec;

    localparam int unsigned WIDTH   = 32;
    localparam int unsigned SHAMT_W = 5;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic [3:0]       ALUControl;
    logic [WIDTH-1:0] SrcA;
    logic [WIDTH-1:0] SrcB;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] ALUResult;
    logic             Zero;
    logic             IllegalOp;

    alu_seq_exec #(.WIDTH(WIDTH), .SHAMT_W(SHAMT_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .ALUControl (ALUControl),
        .SrcA       (SrcA),
        .SrcB       (SrcB),
        .busy       (busy),
        .done       (done),
        .ALUResult  (ALUResult),
        .Zero       (Zero),
        .IllegalOp  (IllegalOp)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        z;
        logic        ill;
    } vec_t;

    typedef struct {
        logic [31:0] res;
        logic        z;
        logic        ill;
    } exp_t;

    int          checks = 0;
    int          errors = 0;
    exp_t        sb[$];
    exp_t        mon_e;
    logic [31:0] last_res;
    vec_t        tbl[18];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic int exp_lat(input logic [3:0] op, input logic [31:0] b);
        int l;
        l = 1;
        if ((op == 4'h7 || op == 4'h8 || op == 4'h9) && b[4:0] != 5'd0)
            l = int'(b[4:0]) + 1;
`ifdef ALU_SEQ_BARREL_SHIFT_EN
        l = 1;
`endif
        return l;
    endfunction

    // Scoreboard: compare registered outputs whenever done pulses
    always @(negedge clk) begin
        if (!reset && done) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done=1 expected no pending op");
            end else begin
                mon_e = sb.pop_front();
                check("result", ALUResult, mon_e.res);
                check("zero", 32'(Zero), 32'(mon_e.z));
                check("illegal", 32'(IllegalOp), 32'(mon_e.ill));
            end
        end
    end

    // Issue one op; poke>0 re-asserts start with junk operands in that wait cycle
    task automatic run(input vec_t v, input int poke, input string tag);
        int   lat;
        int   bc;
        int   el;
        logic stable;
        el = exp_lat(v.op, v.b);
        @(negedge clk);
        ALUControl = v.op;
        SrcA       = v.a;
        SrcB       = v.b;
        start      = 1'b1;
        sb.push_back('{v.res, v.z, v.ill});
        @(negedge clk);
        start      = 1'b0;
        SrcA       = $urandom;
        SrcB       = $urandom;
        ALUControl = 4'($urandom);
        lat    = 1;
        bc     = 0;
        stable = 1'b1;
        while (!done && lat <= 40) begin
            if (busy) bc++;
            if (ALUResult !== last_res) stable = 1'b0;
            start = (poke != 0 && lat == poke);
            @(negedge clk);
            start = 1'b0;
            lat++;
        end
        check($sformatf("%s_latency", tag), 32'(lat), 32'(el));
        check($sformatf("%s_busy_cycles", tag), 32'(bc), 32'(el - 1));
        check($sformatf("%s_busy_at_done", tag), 32'(busy), 32'd0);
        if (el > 1)
            check($sformatf("%s_held_while_busy", tag), 32'(stable), 32'd1);
        last_res = v.res;
    endtask

    initial begin
        bit seen_done;
        tbl[0]  = '{4'h0, 32'h0000_0005, 32'h0000_0003, 32'h0000_0008, 1'b0, 1'b0};
        tbl[1]  = '{4'h1, 32'h0000_0007, 32'h0000_0007, 32'h0000_0000, 1'b1, 1'b0};
        tbl[2]  = '{4'h5, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1'b0, 1'b0};
        tbl[3]  = '{4'h6, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b0};
        tbl[4]  = '{4'h5, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0};
        tbl[5]  = '{4'h2, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1'b0, 1'b0};
        tbl[6]  = '{4'h3, 32'h0F0F_0000, 32'h0000_00F0, 32'h0F0F_00F0, 1'b0, 1'b0};
        tbl[7]  = '{4'h4, 32'hAAAA_AAAA, 32'hFFFF_FFFF, 32'h5555_5555, 1'b0, 1'b0};
        tbl[8]  = '{4'h9, 32'h8000_0000, 32'h0000_0004, 32'hF800_0000, 1'b0, 1'b0};
        tbl[9]  = '{4'h7, 32'h0000_0001, 32'h0000_001F, 32'h8000_0000, 1'b0, 1'b0};
        tbl[10] = '{4'h8, 32'h1234_5678, 32'h0000_0000, 32'h1234_5678, 1'b0, 1'b0};
        tbl[11] = '{4'h8, 32'h8000_0000, 32'h0000_0023, 32'h1000_0000, 1'b0, 1'b0};
        tbl[12] = '{4'h9, 32'h7FFF_FFFF, 32'h0000_0001, 32'h3FFF_FFFF, 1'b0, 1'b0};
        tbl[13] = '{4'hA, 32'h0000_1234, 32'hABCD_0000, 32'hABCD_0000, 1'b0, 1'b0};
        tbl[14] = '{4'hB, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001, 1'b0, 1'b0};
        tbl[15] = '{4'hD, 32'h1234_5678, 32'h9ABC_DEF0, 32'h0000_0000, 1'b1, 1'b1};
        tbl[16] = '{4'h0, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0};
        tbl[17] = '{4'hF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b1};

        reset      = 1'b1;
        start      = 1'b0;
        ALUControl = 4'h0;
        SrcA       = '0;
        SrcB       = '0;
        last_res   = '0;
        repeat (2) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_result", ALUResult, 32'd0);
        check("rst_zero", 32'(Zero), 32'd1);
        check("rst_illegal", 32'(IllegalOp), 32'd0);
        reset = 1'b0;

        for (int i = 0; i < 18; i++)
            run(tbl[i], 0, $sformatf("vec%0d", i));

        // start with junk operands during SHIFT must not disturb the op
        run('{4'h9, 32'h8000_0000, 32'h0000_0004, 32'hF800_0000, 1'b0, 1'b0}, 2, "poke_sra");
        run('{4'h7, 32'h0000_0003, 32'h0000_0008, 32'h0000_0300, 1'b0, 1'b0}, 1, "poke_sll");

`ifndef ALU_SEQ_BARREL_SHIFT_EN
        // Reset in the second SHIFT cycle: no done, back to reset values
        @(negedge clk);
        ALUControl = 4'h7;
        SrcA       = 32'h0000_0001;
        SrcB       = 32'h0000_0008;
        start      = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        check("pre_rst_busy", 32'(busy), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_result", ALUResult, 32'd0);
        check("midrst_zero", 32'(Zero), 32'd1);
        seen_done = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (done) seen_done = 1'b1;
        end
        check("midrst_no_done", 32'(seen_done), 32'd0);
        last_res = '0;
`endif

        run('{4'h0, 32'h0000_0010, 32'h0000_0020, 32'h0000_0030, 1'b0, 1'b0}, 0, "post_rst_add");
        repeat (3) @(negedge clk);
        check("sb_empty", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
